// File: rtl/accumulate_fix.sv
// accumulate_fix: sums a product stream into a wide accumulator and presents each sum on a registered AXI-stream output.
// Define ACCUMULATE_FIX_SAT_EN to clamp overflowing sums to all ones instead of wrapping.
module accumulate_fix #(
    parameter int DATAWIDTH_IN  = 60,
    parameter int DATAWIDTH_OUT = 64,
    parameter int ACC_LEN       = 16,
    parameter int OUTSHIFT      = 0,
    parameter int CW            = $clog2(ACC_LEN) + 1
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     s_axis_prod_tvalid,
    input  logic [DATAWIDTH_IN-1:0]  s_axis_prod_tdata,
    input  logic                     s_axis_prod_tlast,
    output logic                     m_axis_acc_tvalid,
    input  logic                     m_axis_acc_tready,
    output logic [DATAWIDTH_OUT-1:0] m_axis_acc_tdata,
    output logic [CW-1:0]            m_axis_acc_tuser,
    output logic                     m_axis_acc_tsat,
    output logic                     overrun
);
    localparam int ACCW = DATAWIDTH_IN + $clog2(ACC_LEN);
    localparam int RW = (ACCW > DATAWIDTH_OUT) ? ACCW : DATAWIDTH_OUT;
    localparam logic [RW-1:0] MAXO = RW'({DATAWIDTH_OUT{1'b1}});

    logic [ACCW-1:0]          acc_q, acc_d, sum_next;
    logic [CW-1:0]            cnt_q, cnt_d, cnt_next, tuser_q, tuser_d;
    logic [RW-1:0]            r;
    logic [DATAWIDTH_OUT-1:0] red, tdata_q, tdata_d;
    logic                     ovf, comp, load;
    logic                     tvalid_q, tvalid_d, tsat_q, tsat_d, overrun_q, overrun_d;

    always_comb begin
        sum_next = acc_q + ACCW'(s_axis_prod_tdata);
        cnt_next = cnt_q + CW'(1);
        comp = s_axis_prod_tvalid && (cnt_next == CW'(ACC_LEN) || s_axis_prod_tlast);
        r = RW'(sum_next) >> OUTSHIFT;
        ovf = r > MAXO;
`ifdef ACCUMULATE_FIX_SAT_EN
        red = ovf ? '1 : r[DATAWIDTH_OUT-1:0];
`else
        red = r[DATAWIDTH_OUT-1:0];
`endif
        // A completed sum only lands if the register is empty or being drained this edge.
        load = comp && (!tvalid_q || m_axis_acc_tready);
        acc_d = comp ? '0 : s_axis_prod_tvalid ? sum_next : acc_q;
        cnt_d = comp ? '0 : s_axis_prod_tvalid ? cnt_next : cnt_q;
        tvalid_d = load || (tvalid_q && !m_axis_acc_tready);
        tdata_d = load ? red : tdata_q;
        tuser_d = load ? cnt_next : tuser_q;
        tsat_d = load ? ovf : tsat_q;
        overrun_d = overrun_q || (comp && tvalid_q && !m_axis_acc_tready);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            tvalid_q  <= 1'b0;
            tdata_q   <= '0;
            tuser_q   <= '0;
            tsat_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tvalid_q  <= tvalid_d;
            tdata_q   <= tdata_d;
            tuser_q   <= tuser_d;
            tsat_q    <= tsat_d;
            overrun_q <= overrun_d;
        end
    end

    assign m_axis_acc_tvalid = tvalid_q;
    assign m_axis_acc_tdata  = tdata_q;
    assign m_axis_acc_tuser  = tuser_q;
    assign m_axis_acc_tsat   = tsat_q;
    assign overrun           = overrun_q;
endmodule

// File: doc/accumulate_fix.md
# accumulate_fix

Unsigned fixed-point accumulator directly downstream of `multiply_fix`. It sums a stream of products into a wide accumulator, completing a sum after `ACC_LEN` products or on an early `tlast`. Each completed sum is shifted, range-reduced and presented on an AXI-stream-style output with `tready` backpressure. The upstream multiplier cannot stall, so every valid product is always accepted.

## Interface
- `DATAWIDTH_IN`, 60, product width; matches the multiplier's `DATAWIDTH_OUT`.
- `DATAWIDTH_OUT`, 64, output sum width.
- `ACC_LEN`, 16, products per sum; must be ≥2.
- `OUTSHIFT`, 0, right shift applied to the sum before output.
- Derived: `CW = $clog2(ACC_LEN)+1`; `ACCW = DATAWIDTH_IN + $clog2(ACC_LEN)`.

Ports (one clock; reset is asynchronous and active-high):
- `aclk` in 1: clock, rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `s_axis_prod_tvalid` in 1: product valid; no `tready`.
- `s_axis_prod_tdata` in `DATAWIDTH_IN`: unsigned product.
- `s_axis_prod_tlast` in 1: closes the current sum early; qualified by `tvalid`.
- `m_axis_acc_tvalid` out 1: sum valid.
- `m_axis_acc_tready` in 1: downstream accepts the sum.
- `m_axis_acc_tdata` out `DATAWIDTH_OUT`: sum after shift and range reduction.
- `m_axis_acc_tuser` out `CW`: number of products in the sum.
- `m_axis_acc_tsat` out 1: sum exceeded `DATAWIDTH_OUT` after shift.
- `overrun` out 1: sticky; a completed sum was dropped.

## Operation
- Internal state:
  - `acc` (`ACCW` bits); cannot overflow internally.
  - `cnt` (`CW` bits).
  - Output register holding `tdata`/`tuser`/`tsat`.
- Input beat (`s_axis_prod_tvalid`=1): `sum_next = acc + tdata`, `cnt_next = cnt + 1`.
- Completion: a beat where `cnt_next == ACC_LEN` or `tlast`=1.
  - `acc` and `cnt` load 0 on completion, so the next beat starts a fresh sum.
  - Otherwise `acc <= sum_next`, `cnt <= cnt_next`.
- Range reduction: `r = sum_next >> OUTSHIFT`.
  - If `r >= 2^DATAWIDTH_OUT`, `tsat` = 1; data handling is defined in Configuration.
  - Otherwise `tdata = r` and `tsat` = 0.
- Output register states: EMPTY (`tvalid`=0) and FULL (`tvalid`=1).
  - EMPTY + completion → load the register, go to FULL.
  - FULL + `tready`=1, no completion → EMPTY.
  - FULL + `tready`=1 + completion on the same edge → load the new sum, stay FULL. No overrun.
  - FULL + `tready`=0 + completion → the new sum is dropped, the held sum is unchanged, `overrun` is set. Accumulation restarts normally.
- `overrun` clears only on `areset`.
- Idle cycles (`tvalid`=0) leave `acc` and `cnt` unchanged. The `tlast` and `tdata` inputs are ignored when `tvalid`=0.

## Timing
- Reset values: `m_axis_acc_tvalid`=0, `tdata`=0, `tuser`=0, `tsat`=0, `overrun`=0; `acc`=0, `cnt`=0.
- Reset mid-sum discards the partial sum and any held output.
- Latency: a sum is visible on `m_axis_acc_*` one cycle after the edge that captures its final product.
- Back-to-back sums: with `ACC_LEN` valid beats per sum and `tready` held 1, sustained throughput is one sum per `ACC_LEN` cycles.
- An isolated `tlast` beat (`cnt`=0) completes a 1-product sum with `tuser`=1.
- `tdata`/`tuser`/`tsat` are stable while `tvalid`=1 and `tready`=0.

## Configuration
- `ACCUMULATE_FIX_SAT_EN` defined: on overflow, `tdata` = all ones (`2^DATAWIDTH_OUT - 1`).
- `ACCUMULATE_FIX_SAT_EN` undefined: on overflow, `tdata` = `r[DATAWIDTH_OUT-1:0]` (wrap).
- `tsat` reports overflow identically in both builds.

## Test plan
- `ACC_LEN`=4, `tready`=1, products 1,2,3,4 on consecutive cycles → `tvalid` for 1 cycle, one cycle after the 4th product; `tdata`=10, `tuser`=4. A following 5,5,5,5 → `tdata`=20.
- Products 5 then 7 with `tlast` on 7 → `tdata`=12, `tuser`=2. The next four products 1 each → `tdata`=4, `tuser`=4.
- `tready`=0, two full sums (10, then 20) → `tdata` holds 10, `overrun`=1 after the second completion. Raising `tready` → 10 is accepted, `tvalid` drops, and 20 is never seen.
- Completion on the same edge as acceptance of a held sum → `tvalid` stays 1, the new sum appears next cycle, `overrun` stays 0.
- `DATAWIDTH_OUT`=8, `OUTSHIFT`=0, products 100,100,50,50 → `tsat`=1; `tdata`=255 with the macro, 44 without. Same stimulus with `OUTSHIFT`=1 → `tdata`=150, `tsat`=0.
- `areset` pulsed after 2 of 4 products → all outputs 0. The next 4 products (1 each) → `tdata`=4, `tuser`=4.
